// File: rtl/fila_pkg.sv
// Shared types and width helpers for the instruction issue queue.
// Queue entries are packed as {cpu, instr}, with the cpu id in the upper bits.
package fila_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } fila_state_e;

    function automatic int cpu_w(input int num_cpu);
        return (num_cpu > 1) ? $clog2(num_cpu) : 1;
    endfunction

    function automatic int entry_w(input int cpu_width, input int instr_width);
        return cpu_width + instr_width;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered occupancy flags; head entry is read combinationally.
module instr_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == (AW+1)'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;

endmodule

// File: rtl/fila_instr_param.sv
// Instruction issue queue: buffers cpu-tagged instructions and grants the snoop bus to one node at a time.
// state        | meaning
// ST_IDLE      | bus free, waiting for a queued entry
// ST_ISSUE     | one cycle: head popped, issue_valid pulsed, target node emits
// ST_WAIT_DONE | issued node keeps emitting until bus_done
// ST_GAP       | enforced idle cycles after a completed transaction
module fila_instr_param
    import fila_pkg::*;
#(
    parameter int NUM_CPU = 3,
    parameter int INSTR_W = 8,
    parameter int DEPTH   = 8,
    parameter int GAP     = 2,
    parameter int CPU_W   = cpu_w(NUM_CPU)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [CPU_W-1:0]         wr_cpu,
    input  logic [INSTR_W-1:0]       wr_instr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     bus_done,
    output logic [NUM_CPU-1:0]       modo_cpu,
    output logic [INSTR_W-1:0]       instr,
    output logic                     issue_valid,
    output logic                     err
);

    localparam int EW = entry_w(CPU_W, INSTR_W);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef struct packed {
        logic [CPU_W-1:0]   cpu;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fila_state_e        state_q, state_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [NUM_CPU-1:0] modo_q, modo_d, head_onehot;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               issue_valid_q, issue_valid_d;
    logic               err_q, err_d;
    logic               legal_cpu, fifo_full, fifo_empty;
    entry_t             wr_entry, head;

    assign legal_cpu = ({1'b0, wr_cpu} < (CPU_W+1)'(NUM_CPU));
    assign wr_entry  = '{cpu: wr_cpu, instr: wr_instr};

    instr_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i   (clock),
        .reset_i   (reset),
        .push_i    (wr_en && legal_cpu),
        .wr_data_i (wr_entry),
        .pop_i     (state_q == ST_ISSUE),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level)
    );

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            head_onehot[i] = (head.cpu == CPU_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT_DONE: begin
                if (bus_done) begin
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are computed from the state being entered.
        modo_d        = '0;
        instr_d       = '0;
        issue_valid_d = 1'b0;
        if (state_d == ST_ISSUE) begin
            modo_d        = head_onehot;
            instr_d       = head.instr;
            issue_valid_d = 1'b1;
        end else if (state_d == ST_WAIT_DONE) begin
            modo_d  = modo_q;
            instr_d = instr_q;
        end

        err_d = err_q | (wr_en & (fifo_full | ~legal_cpu));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gap_cnt_q     <= '0;
            modo_q        <= '0;
            instr_q       <= '0;
            issue_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            modo_q        <= modo_d;
            instr_q       <= instr_d;
            issue_valid_q <= issue_valid_d;
            err_q         <= err_d;
        end
    end

    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign modo_cpu    = modo_q;
    assign instr       = instr_q;
    assign issue_valid = issue_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fila_instr_param.sv
// Bench for fila_instr_param: two configurations checked every cycle against a timeline-based queue model.
module tb_fila_instr_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // instance 0: NUM_CPU=3 DEPTH=8 GAP=2
    logic       we0, bd0, full0, empty0, iv0, err0;
    logic [1:0] cpu0;
    logic [7:0] ins0, instr0;
    logic [3:0] lvl0;
    logic [2:0] modo0;

    // instance 1: NUM_CPU=5 DEPTH=4 GAP=0
    logic       we1, bd1, full1, empty1, iv1, err1;
    logic [2:0] cpu1;
    logic [7:0] ins1, instr1;
    logic [2:0] lvl1;
    logic [4:0] modo1;

    fila_instr_param u_dut0 (
        .clock(clock), .reset(reset), .wr_en(we0), .wr_cpu(cpu0), .wr_instr(ins0),
        .full(full0), .empty(empty0), .level(lvl0), .bus_done(bd0),
        .modo_cpu(modo0), .instr(instr0), .issue_valid(iv0), .err(err0)
    );

    fila_instr_param #(.NUM_CPU(5), .INSTR_W(8), .DEPTH(4), .GAP(0)) u_dut1 (
        .clock(clock), .reset(reset), .wr_en(we1), .wr_cpu(cpu1), .wr_instr(ins1),
        .full(full1), .empty(empty1), .level(lvl1), .bus_done(bd1),
        .modo_cpu(modo1), .instr(instr1), .issue_valid(iv1), .err(err1)
    );

    localparam int NCP [2] = '{3, 5};
    localparam int DEP [2] = '{8, 4};
    localparam int GP  [2] = '{2, 0};

    // Model: a list of queued entries (cpu*256+instr), the outstanding grant,
    // and the first cycle at which a new issue decision may be taken.
    int  ent [2][8];
    int  cnt [2];
    bit  busy [2];
    int  cur [2];
    int  idle_from [2];
    bit  m_err [2];
    bit  e_iv [2];
    int  n = 0;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input bit rst, input bit we, input int cpu,
                              input int ins, input bit bd);
        bit full_pre, was_issue, issue_now;
        if (rst) begin
            cnt[k] = 0; busy[k] = 0; idle_from[k] = n + 1; m_err[k] = 0; e_iv[k] = 0;
            return;
        end
        full_pre  = (cnt[k] == DEP[k]);
        was_issue = e_iv[k];
        issue_now = 0;
        if (busy[k] && bd) begin
            busy[k] = 0;
            idle_from[k] = n + 1 + GP[k];
        end else if (!busy[k] && n >= idle_from[k] && cnt[k] > 0) begin
            busy[k] = 1;
            cur[k] = ent[k][0];
            issue_now = 1;
        end
        if (was_issue) begin
            for (int i = 0; i < 7; i++) ent[k][i] = ent[k][i+1];
            cnt[k]--;
        end
        if (we) begin
            if (full_pre || cpu >= NCP[k]) m_err[k] = 1;
            else begin
                ent[k][cnt[k]] = cpu * 256 + ins;
                cnt[k]++;
            end
        end
        e_iv[k] = issue_now;
    endtask

    always @(posedge clock) begin
        model_edge(0, reset, we0, int'(cpu0), int'(ins0), bd0);
        model_edge(1, reset, we1, int'(cpu1), int'(ins1), bd1);
        n++;
    end

    task automatic cmp_inst(input int k);
        int a_modo, a_instr, a_iv, a_lvl, a_emp, a_full, a_err;
        if (k == 0) begin
            a_modo = int'(modo0); a_instr = int'(instr0); a_iv = int'(iv0); a_lvl = int'(lvl0);
            a_emp = int'(empty0); a_full = int'(full0); a_err = int'(err0);
        end else begin
            a_modo = int'(modo1); a_instr = int'(instr1); a_iv = int'(iv1); a_lvl = int'(lvl1);
            a_emp = int'(empty1); a_full = int'(full1); a_err = int'(err1);
        end
        chk($sformatf("u%0d_modo_cpu", k), a_modo, busy[k] ? (1 << (cur[k] / 256)) : 0);
        chk($sformatf("u%0d_instr", k), a_instr, busy[k] ? (cur[k] % 256) : 0);
        chk($sformatf("u%0d_issue_valid", k), a_iv, int'(e_iv[k]));
        chk($sformatf("u%0d_level", k), a_lvl, cnt[k]);
        chk($sformatf("u%0d_empty", k), a_emp, int'(cnt[k] == 0));
        chk($sformatf("u%0d_full", k), a_full, int'(cnt[k] == DEP[k]));
        chk($sformatf("u%0d_err", k), a_err, int'(m_err[k]));
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            cmp_inst(0);
            cmp_inst(1);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        we0 = 0; cpu0 = '0; ins0 = '0; bd0 = 0;
        we1 = 0; cpu1 = '0; ins1 = '0; bd1 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int iss_modo [8];
    int iss_t [8];
    int n_iss;

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_level", int'(lvl0), 0);
        chk("reset_empty", int'(empty0), 1);
        chk("reset_modo", int'(modo0), 0);
        reset = 1'b0;

        // single issue, bus_done three cycles after the issue, then two gap cycles
        we0 = 1; cpu0 = 2'd1; ins0 = 8'hA5;
        tick();
        we0 = 0;
        chk("t1_no_early_issue", int'(iv0), 0);
        tick();
        chk("t1_issue_valid", int'(iv0), 1);
        chk("t1_modo", int'(modo0), 3'b010);
        chk("t1_instr", int'(instr0), 8'hA5);
        tick();
        chk("t1_single_pulse", int'(iv0), 0);
        chk("t1_modo_hold1", int'(modo0), 3'b010);
        tick();
        chk("t1_modo_hold2", int'(modo0), 3'b010);
        tick();
        chk("t1_modo_hold3", int'(modo0), 3'b010);
        chk("t1_instr_hold", int'(instr0), 8'hA5);
        bd0 = 1;
        tick();
        bd0 = 0;
        chk("t1_gap_modo_a", int'(modo0), 0);
        chk("t1_gap_instr", int'(instr0), 0);
        tick();
        chk("t1_gap_modo_b", int'(modo0), 0);
        tick();

        // illegal cpu id
        do_reset();
        we0 = 1; cpu0 = 2'd3; ins0 = 8'h33;
        tick();
        we0 = 0;
        chk("t3_level", int'(lvl0), 0);
        chk("t3_err", int'(err0), 1);
        chk("t3_empty", int'(empty0), 1);

        // fill while a transaction is outstanding, then overflow
        do_reset();
        we0 = 1; cpu0 = 2'd0; ins0 = 8'h11;
        tick();
        we0 = 0;
        tick();
        chk("t2_first_issue", int'(iv0), 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            we0 = 1; cpu0 = 2'(i % 3); ins0 = 8'(8'h20 + i);
            tick();
        end
        chk("t2_full", int'(full0), 1);
        chk("t2_level8", int'(lvl0), 8);
        chk("t2_err_clear", int'(err0), 0);
        cpu0 = 2'd0; ins0 = 8'hEE;
        tick();
        we0 = 0;
        chk("t2_overflow_level", int'(lvl0), 8);
        chk("t2_overflow_err", int'(err0), 1);

        // reset during WAIT_DONE with entries queued
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_modo", int'(modo0), 0);
        chk("t5_level", int'(lvl0), 0);
        chk("t5_empty", int'(empty0), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_issue", int'(iv0), 0);
        end

        // GAP=0, bus_done tied high: issue every two cycles in push order
        bd1 = 1;
        n_iss = 0;
        for (int i = 0; i < 14; i++) begin
            we1 = (i < 3);
            cpu1 = (i == 0) ? 3'd0 : (i == 1) ? 3'd2 : 3'd1;
            ins1 = 8'(8'h10 + i);
            tick();
            if (iv1 && n_iss < 8) begin
                iss_modo[n_iss] = int'(modo1);
                iss_t[n_iss] = i;
                n_iss++;
            end
        end
        we1 = 0;
        chk("t4_issue_count", n_iss, 3);
        chk("t4_modo_first", iss_modo[0], 5'b00001);
        chk("t4_modo_second", iss_modo[1], 5'b00100);
        chk("t4_modo_third", iss_modo[2], 5'b00010);
        chk("t4_spacing_a", iss_t[1] - iss_t[0], 2);
        chk("t4_spacing_b", iss_t[2] - iss_t[1], 2);

        // overlapping push and pop across many pointer wraps
        for (int i = 0; i < 86; i++) begin
            we1 = (i < 2) ? 1'b1 : iv1;
            cpu1 = 3'($urandom_range(0, 4));
            ins1 = 8'($urandom_range(0, 255));
            tick();
            if (i >= 1) chk("t6_level_const", int'(lvl1), 2);
        end
        we1 = 0;
        bd1 = 0;

        // randomized traffic on both instances
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            we0  = ($urandom_range(0, 2) != 0);
            cpu0 = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ins0 = 8'($urandom_range(0, 255));
            bd0  = ($urandom_range(0, 3) == 0);
            we1  = ($urandom_range(0, 2) != 0);
            cpu1 = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            ins1 = 8'($urandom_range(0, 255));
            bd1  = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fila_instr_param.md
# fila_instr_param

Parametrised instruction issue queue for the snooping-coherence testbench system. It buffers CPU-tagged instructions and issues them one at a time to the processor/cache nodes. It drives a one-hot emit/listen mode vector so that at most one node emits on the snoop bus. It waits for the bus transaction to complete, then enforces a programmable idle gap before the next issue.

## Interface
- `NUM_CPU`, 3: number of processor nodes; must be ≥ 2.
- `INSTR_W`, 8: instruction width in bits.
- `DEPTH`, 8: queue entries; must be a power of two, ≥ 2.
- `GAP`, 2: idle cycles inserted after each completed transaction; 0 is legal.
- `CPU_W`, derived as $clog2(NUM_CPU): width of the CPU id field.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: push request.
- `wr_cpu` in CPU_W: target node id of the pushed instruction.
- `wr_instr` in INSTR_W: instruction to push.
- `full` out 1: queue holds DEPTH entries.
- `empty` out 1: queue holds 0 entries.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `bus_done` in 1: pulse from the bus/cache side; the issued transaction has completed.
- `modo_cpu` out NUM_CPU: one-hot emit mode; bit i=1 means node i emits and all others listen.
- `instr` out INSTR_W: issued instruction, held stable while `modo_cpu` is nonzero.
- `issue_valid` out 1: single-cycle pulse marking a new issue.
- `err` out 1: sticky; set on a push to a full queue or a push with `wr_cpu` ≥ NUM_CPU.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT_DONE and GAP.
- IDLE → ISSUE when `empty`=0. ISSUE lasts exactly one cycle.
  - It pops the head entry.
  - It drives `issue_valid`=1, `modo_cpu`=1<<cpu and `instr`=head instruction.
- ISSUE → WAIT_DONE, or directly to GAP/IDLE if `bus_done`=1 in the ISSUE cycle.
- In WAIT_DONE, `modo_cpu` and `instr` hold their issued values. On `bus_done`=1 the FSM moves to GAP (GAP>0) or IDLE (GAP=0).
- `bus_done` outside ISSUE/WAIT_DONE is ignored.
- In GAP, a counter loads GAP-1 and decrements to 0, then the FSM returns to IDLE. Total idle is GAP cycles.
- `modo_cpu`=0 and `instr`=0 in IDLE and GAP.
- Push rules:
  - A push is accepted when `wr_en`=1, `full`=0 and `wr_cpu`<NUM_CPU.
  - A push to a full queue is dropped and sets `err`. This holds even if a pop occurs in the same cycle, since `full` is the pre-edge value.
  - A push with an illegal `wr_cpu` is dropped and sets `err`.
- A simultaneous accepted push and pop leaves `level` unchanged.
- Pointers wrap modulo DEPTH.
- `err` clears only on reset.

## Timing
- Reset values:
  - State IDLE; pointers 0.
  - `level`=0, `empty`=1, `full`=0.
  - `modo_cpu`=0, `instr`=0, `issue_valid`=0, `err`=0.
- Reset mid-transaction aborts it. The queue contents are discarded and `modo_cpu` returns to 0 in the next cycle.
- All outputs are registered.
- Latency: a push at edge t into an empty queue with the FSM in IDLE gives `issue_valid`=1 in the cycle after edge t+1.
- `level`, `empty` and `full` update on the edge that accepts the push or pop.
- Minimum issue-to-issue spacing is 2+GAP cycles, reached when `bus_done` arrives in the ISSUE cycle.

## Structure
- Package `fila_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT_DONE, GAP);
  - the width helper for CPU_W;
  - the entry layout {cpu, instr}.
- Sub-module `instr_fifo`: a synchronous FIFO of width CPU_W+INSTR_W and depth DEPTH, providing push/pop/full/empty/level.
- The top level contains the FSM, the gap counter, the one-hot decode and the err flag.

## Test plan
- Defaults; push (cpu1, 8'hA5); `bus_done` 3 cycles after issue → `issue_valid` pulses once two cycles after the push; `modo_cpu`=3'b010 and `instr`=8'hA5 for 4 cycles; then 2 idle cycles with `modo_cpu`=0.
- Push 8 entries back-to-back, then a 9th → `full`=1 after the 8th; the 9th is dropped; `err`=1; `level`=8.
- Push cpu id 3 with NUM_CPU=3 → `level` stays 0 and `err`=1.
- Push three entries (cpu0, cpu2, cpu1) with `bus_done` tied to 1 and GAP=0 → issues every 2 cycles; `modo_cpu` sequence is 001, 100, 010; never two bits set.
- Assert reset during WAIT_DONE with 3 entries queued → the next cycle has `modo_cpu`=0, `level`=0, `empty`=1; no issue follows.
- NUM_CPU=5, DEPTH=4, GAP=0: push and pop simultaneously across wrap 10 times → FIFO order preserved; `level` is constant while pushes and pops overlap.
